rs_dec_single: RTL and testbench

- Streaming Reed-Solomon decoder for the 4-parity GF(256) code produced by the team's RS encoder.
  - Field polynomial 0x11d.
  - Generator g(x) = x^4 + 0x0f x^3 + 0x36 x^2 + 0x78 x + 0x40, with roots alpha^0..alpha^3.
- Accepts N-symbol codewords, first symbol = highest degree.
- Computes the 4 syndromes and corrects any single-symbol error in the symbol stream.
- Flags frames with 2 or more errors as uncorrectable; those frames are passed through unmodified.
- Sits on the receive side, directly after the deframer.

---
 rtl/rs_pkg.sv | 37 +++
 rtl/rs_syndrome.sv | 34 +++
 rtl/rs_dec_single.sv | 130 +++++++++++++
 tb/tb_rs_dec_single.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/rs_pkg.sv
// GF(256) helpers and shared types for the 4-parity Reed-Solomon code (field poly 0x11d).
package rs_pkg;

  localparam logic [7:0] GF_POLY = 8'h1d;

  // Decision-stage snapshot of one closed frame.
  typedef struct packed {
    logic       clean;
    logic       single;
    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] z;
    logic       bank;
  } dec_t;

  // Generic GF(256) multiply, shift-and-add with reduction by 0x11d.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? GF_POLY : 8'h00);
    end
    return p;
  endfunction

  // alpha^e with alpha = 0x02; used for elaboration-time constants.
  function automatic logic [7:0] gf_pow(input int unsigned e);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < e; i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

endpackage

// File: rtl/rs_syndrome.sv
// Four Horner accumulators S_k = S_k*alpha^k ^ din, restarted on the first symbol of a frame.
module rs_syndrome
  import rs_pkg::*;
(
  input  logic            clk,
  input  logic            nrst,
  input  logic            valid,
  input  logic            clear,
  input  logic            last,
  input  logic [7:0]      din,
  output logic [3:0][7:0] s,
  output logic            frame_done
);

  logic [3:0][7:0] s_nxt;

  for (genvar k = 0; k < 4; k++) begin : g_acc
    localparam logic [7:0] AK = gf_pow(k);
    // clear replaces the old sum so back-to-back frames need no idle cycle
    assign s_nxt[k] = (clear ? 8'h00 : gf_mul(s[k], AK)) ^ din;
  end

  // Accumulate on accepted symbols; pulse frame_done the cycle after the closing symbol.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= valid && last;
      if (valid) s <= s_nxt;
    end
  end

endmodule

// File: rtl/rs_dec_single.sv
// Streaming single-error RS decoder: syndromes, decision, ping-pong buffer, location search.
module rs_dec_single
  import rs_pkg::*;
#(
  parameter int N = 20
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       in_valid,
  input  logic [7:0] in,
  output logic       out_valid,
  output logic [7:0] out,
  output logic       out_last,
  output logic       corrected,
  output logic       uncorrectable
);

  localparam int         CW    = $clog2(N);
  localparam logic [7:0] A_N1  = gf_pow(N - 1);
  localparam logic [7:0] A_INV = gf_pow(254);

  logic [CW-1:0]   cnt;
  logic            wr_bank;
  logic            first_sym;
  logic            last_sym;
  logic [7:0]      mem [2][N];
  logic [3:0][7:0] s;
  logic            frame_done;
  dec_t            dec_nxt;
  dec_t            dec1;
  dec_t            act;
  logic            dec_vld;
  logic            rd_active;
  logic [CW-1:0]   rd_idx;
  logic            found;
  logic            match;
  logic            rd_last;
  logic            fixed;

  assign first_sym = (cnt == '0);
  assign last_sym  = (cnt == CW'(N - 1));

  rs_syndrome u_syn (
    .clk        (clk),
    .nrst       (nrst),
    .valid      (in_valid),
    .clear      (first_sym),
    .last       (last_sym),
    .din        (in),
    .s          (s),
    .frame_done (frame_done)
  );

  // Input symbol counter; the closing symbol wraps it and flips the write bank.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt     <= '0;
      wr_bank <= 1'b0;
    end else if (in_valid) begin
      cnt <= last_sym ? '0 : cnt + CW'(1);
      if (last_sym) wr_bank <= ~wr_bank;
    end
  end

  // Symbol store; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_valid) mem[wr_bank][cnt] <= in;
  end

  // Frame classification from the final syndromes; wr_bank has already flipped.
  always_comb begin
    dec_nxt        = '0;
    dec_nxt.clean  = (s == '0);
    dec_nxt.single = (s[0] != 8'h00) && (s[1] != 8'h00) &&
                     (gf_mul(s[1], s[1]) == gf_mul(s[0], s[2])) &&
                     (gf_mul(s[2], s[2]) == gf_mul(s[1], s[3]));
    dec_nxt.s0     = s[0];
    dec_nxt.s1     = s[1];
    dec_nxt.z      = gf_mul(s[0], A_N1);
    dec_nxt.bank   = ~wr_bank;
  end

  // Decision latch; held separately so a new frame cannot disturb the one still being output.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      dec1    <= '0;
      dec_vld <= 1'b0;
    end else begin
      dec_vld <= frame_done;
      if (frame_done) dec1 <= dec_nxt;
    end
  end

  assign match   = rd_active && act.single && !found && (act.z == act.s1);
  assign rd_last = rd_active && (rd_idx == CW'(N - 1));
  assign fixed   = act.single && (found || match);

  // Output sweep: walk degree N-1..0, fix the matching symbol, flag status with the last one.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      act           <= '0;
      rd_active     <= 1'b0;
      rd_idx        <= '0;
      found         <= 1'b0;
      out_valid     <= 1'b0;
      out           <= 8'h00;
      out_last      <= 1'b0;
      corrected     <= 1'b0;
      uncorrectable <= 1'b0;
    end else begin
      out_valid     <= rd_active;
      out           <= rd_active ? (mem[act.bank][rd_idx] ^ (match ? act.s0 : 8'h00)) : 8'h00;
      out_last      <= rd_last;
      corrected     <= rd_last && fixed;
      uncorrectable <= rd_last && !act.clean && !fixed;
      if (dec_vld) begin
        act       <= dec1;
        rd_active <= 1'b1;
        rd_idx    <= '0;
        found     <= 1'b0;
      end else if (rd_active) begin
        act.z  <= gf_mul(act.z, A_INV);
        rd_idx <= rd_idx + CW'(1);
        found  <= found || match;
        if (rd_last) rd_active <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_dec_single.sv
// Directed bench for rs_dec_single: N=5 and N=20 instances, cycle-stamped output capture.
module tb_rs_dec_single;

  logic       clk = 1'b0;
  logic       nrst;
  logic       iv5, iv20;
  logic [7:0] in5, in20;
  logic       ov5, ol5, c5, u5;
  logic       ov20, ol20, c20, u20;
  logic [7:0] o5, o20;

  always #5 clk = ~clk;

  rs_dec_single #(.N(5)) dut5 (
    .clk(clk), .nrst(nrst), .in_valid(iv5), .in(in5),
    .out_valid(ov5), .out(o5), .out_last(ol5), .corrected(c5), .uncorrectable(u5)
  );

  rs_dec_single #(.N(20)) dut20 (
    .clk(clk), .nrst(nrst), .in_valid(iv20), .in(in20),
    .out_valid(ov20), .out(o20), .out_last(ol20), .corrected(c20), .uncorrectable(u20)
  );

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       cor;
    logic       unc;
    int         cyc;
  } ev_t;

  ev_t q5[$];
  ev_t q20[$];
  int  cyc = 0;
  int  n_chk = 0, n_pass = 0, n_fail = 0;
  int  close5, close20;

  always @(posedge clk) cyc <= cyc + 1;

  // capture every output beat with the index of the edge that produced it
  always @(negedge clk) begin
    if (ov5)  q5.push_back('{o5, ol5, c5, u5, cyc});
    if (ov20) q20.push_back('{o20, ol20, c20, u20, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send5(input logic [39:0] f, input logic [4:0] gaps);
    for (int i = 0; i < 5; i++) begin
      if (gaps[i]) begin
        @(negedge clk); iv5 = 1'b0; in5 = 8'h00;
      end
      @(negedge clk); iv5 = 1'b1; in5 = f[39-8*i -: 8]; close5 = cyc + 1;
    end
  endtask

  task automatic end5();
    @(negedge clk); iv5 = 1'b0; in5 = 8'h00;
  endtask

  task automatic send20(input logic [7:0] last_sym);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); iv20 = 1'b1; in20 = (i == 19) ? last_sym : 8'h00; close20 = cyc + 1;
    end
  endtask

  task automatic pop_ev(input bit big, output ev_t e, output bit ok);
    int w;
    w = 0;
    while (((big ? q20.size() : q5.size()) == 0) && w < 100) begin
      @(negedge clk); w++;
    end
    ok = (big ? q20.size() : q5.size()) != 0;
    if (ok) begin
      if (big) e = q20.pop_front();
      else     e = q5.pop_front();
    end
  endtask

  // expected frame: symbol i (first = highest degree) in exp[8*(n-1-i) +: 8]
  task automatic check_frame(input string tag, input bit big, input int n, input logic [159:0] exp,
                             input bit cor, input bit unc, input int close);
    ev_t e;
    bit  ok;
    bit  lst;
    for (int i = 0; i < n; i++) begin
      pop_ev(big, e, ok);
      if (!ok) begin
        n_chk++; n_fail++;
        $error("FAIL %s timeout: observed no beat %0d expected %0d beats", tag, i, n);
        return;
      end
      lst = (i == n - 1);
      chk($sformatf("%s d[%0d]", tag, i), 32'(e.d), 32'(exp[8*(n-1-i) +: 8]));
      chk($sformatf("%s flags[%0d]", tag, i), 32'({e.last, e.cor, e.unc}),
          32'({lst, cor && lst, unc && lst}));
      chk($sformatf("%s cyc[%0d]", tag, i), 32'(e.cyc), 32'(close + 3 + i));
    end
  endtask

  initial begin
    int ca, cb, cc;
    nrst = 1'b0; iv5 = 1'b0; iv20 = 1'b0; in5 = 8'h00; in20 = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset5",  32'({ov5, o5, ol5, c5, u5}), 32'h0);
    chk("reset20", 32'({ov20, o20, ol20, c20, u20}), 32'h0);
    nrst = 1'b1;
    @(negedge clk);

    // clean codeword g(x)
    send5(40'h010f367840, 5'b00000); ca = close5; end5();
    check_frame("clean", 1'b0, 5, 160'h010f367840, 1'b0, 1'b0, ca);

    // single error in third symbol
    send5(40'h010f377840, 5'b00000); ca = close5; end5();
    check_frame("single", 1'b0, 5, 160'h010f367840, 1'b1, 1'b0, ca);

    // two errors: first and last symbols, passed through unmodified
    send5(40'h000f367841, 5'b00000); ca = close5; end5();
    check_frame("double", 1'b0, 5, 160'h000f367841, 1'b0, 1'b1, ca);

    // N=20: zero frame, then error 0xAA in the last (degree 0) symbol
    send20(8'h00); ca = close20;
    send20(8'hAA); cb = close20;
    @(negedge clk); iv20 = 1'b0; in20 = 8'h00;
    check_frame("z20a", 1'b1, 20, 160'h0, 1'b0, 1'b0, ca);
    check_frame("z20b", 1'b1, 20, 160'h0, 1'b1, 1'b0, cb);

    // back-to-back clean frames (g and 2*g), then g with gaps
    send5(40'h010f367840, 5'b00000); ca = close5;
    send5(40'h021e6cf080, 5'b00000); cb = close5;
    send5(40'h010f367840, 5'b10110); cc = close5;
    end5();
    check_frame("b2b_a", 1'b0, 5, 160'h010f367840, 1'b0, 1'b0, ca);
    check_frame("b2b_b", 1'b0, 5, 160'h021e6cf080, 1'b0, 1'b0, cb);
    check_frame("gap_c", 1'b0, 5, 160'h010f367840, 1'b0, 1'b0, cc);
    repeat (10) @(negedge clk);
    chk("b2b_extra", 32'(q5.size()), 32'd0);

    // reset during frame 0 output and after 3 symbols of frame 1
    send5(40'h010f367840, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); iv5 = 1'b1; in5 = 8'h55;
    end
    @(negedge clk); iv5 = 1'b0; in5 = 8'h00;
    chk("rst_pre_ov", 32'(ov5), 32'd1);
    #2 nrst = 1'b0;
    #1 chk("rst_async", 32'({ov5, o5, ol5, c5, u5}), 32'h0);
    @(negedge clk); nrst = 1'b1;
    q5.delete();
    send5(40'h010f367840, 5'b00000); ca = close5; end5();
    check_frame("post_rst", 1'b0, 5, 160'h010f367840, 1'b0, 1'b0, ca);
    repeat (10) @(negedge clk);
    chk("post_rst_extra", 32'(q5.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
